// File: rtl/run_controller_pkg.sv
// Shared run-control types: run states, halt causes and CPU error bit positions.
package run_controller_pkg;

  localparam int unsigned RUN_RESET_CYCLES = 2;
  localparam int unsigned RUN_COUNT_WIDTH  = 32;

  typedef enum int unsigned {
    CPU_ERR_DECODER = 0,
    CPU_ERR_ALU     = 1
  } cpu_error_bit_e;

  typedef enum logic [2:0] {
    ST_RESET_HOLD = 3'd0,
    ST_RUN        = 3'd1,
    ST_STEP_WAIT  = 3'd2,
    ST_DRAIN      = 3'd3,
    ST_HALTED     = 3'd4,
    ST_ERROR      = 3'd5
  } run_state_e;

  typedef enum logic [1:0] {
    HC_NONE    = 2'd0,
    HC_EBREAK  = 2'd1,
    HC_ERROR   = 2'd2,
    HC_TIMEOUT = 2'd3
  } halt_cause_e;

endpackage

// File: rtl/run_controller_saturating_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module saturating_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (en && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/run_controller.sv
// CPU run control: reset sequencing, free/step clock enable, EBREAK drain,
// error and cycle-budget halts with latched cause, error bits and cycle count.
module run_controller
  import run_controller_pkg::*;
#(
  parameter int unsigned RESET_CYCLES = RUN_RESET_CYCLES,
  parameter int unsigned ERROR_WIDTH  = 2,
  parameter int unsigned COUNT_WIDTH  = RUN_COUNT_WIDTH,
  parameter int unsigned MAX_CYCLES   = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run_mode,
  input  logic                   step_req,
  input  logic                   cpu_stop,
  input  logic [ERROR_WIDTH-1:0] cpu_error,
  output logic                   cpu_reset,
  output logic                   cpu_clk_en,
  output logic [2:0]             state,
  output logic [1:0]             halt_cause,
  output logic [ERROR_WIDTH-1:0] error_latched,
  output logic [COUNT_WIDTH-1:0] cycle_count,
  output logic                   done
);

  localparam int unsigned HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [HOLD_W-1:0]      HOLD_INIT  = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] LAST_CYCLE = COUNT_WIDTH'(MAX_CYCLES - 1);
  localparam bit                     TIMEOUT_ON = (MAX_CYCLES != 0);

  run_state_e        cur_state;
  run_state_e        nxt_state;
  run_state_e        mode_state;
  halt_cause_e       cause_q;
  halt_cause_e       nxt_cause;
  logic [HOLD_W-1:0] hold_cnt;
  logic              clk_en;
  logic              set_cause;
  logic              err_hit;
  logic              grant;

  // Next state and clock enable; a halt decision never grants an extra cycle.
  always_comb begin
    nxt_state  = cur_state;
    nxt_cause  = HC_NONE;
    clk_en     = 1'b0;
    set_cause  = 1'b0;
    err_hit    = 1'b0;
    mode_state = run_mode ? ST_STEP_WAIT : ST_RUN;
    grant      = (cur_state == ST_RUN) || ((cur_state == ST_STEP_WAIT) && step_req);
    unique case (cur_state)
      ST_RESET_HOLD: begin
        clk_en = 1'b1;
        if (hold_cnt == '0) nxt_state = mode_state;
      end
      ST_RUN, ST_STEP_WAIT: begin
        if (cpu_error != '0) begin
          nxt_state = ST_ERROR;
          nxt_cause = HC_ERROR;
          set_cause = 1'b1;
          err_hit   = 1'b1;
        end else if (!grant) begin
          nxt_state = mode_state;
        end else begin
          clk_en = 1'b1;
          if (cpu_stop) begin
            nxt_state = ST_DRAIN;
          end else if (TIMEOUT_ON && (cycle_count == LAST_CYCLE)) begin
            nxt_state = ST_HALTED;
            nxt_cause = HC_TIMEOUT;
            set_cause = 1'b1;
          end else begin
            nxt_state = mode_state;
          end
        end
      end
      ST_DRAIN: begin
        nxt_state = ST_HALTED;
        nxt_cause = HC_EBREAK;
        set_cause = 1'b1;
      end
      default: begin
        nxt_state = cur_state;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) cur_state <= ST_RESET_HOLD;
    else       cur_state <= nxt_state;
  end

  // Reset-hold countdown and latched halt reporting.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt      <= HOLD_INIT;
      cause_q       <= HC_NONE;
      error_latched <= '0;
      done          <= 1'b0;
    end else begin
      if ((cur_state == ST_RESET_HOLD) && (hold_cnt != '0)) hold_cnt <= hold_cnt - HOLD_W'(1);
      if (set_cause) cause_q <= nxt_cause;
      if (err_hit) error_latched <= cpu_error;
      done <= set_cause;
    end
  end

  saturating_counter #(
    .WIDTH(COUNT_WIDTH)
  ) u_cycle_counter (
    .clk   (clk),
    .clear (reset),
    .en    (clk_en && (cur_state != ST_RESET_HOLD)),
    .count (cycle_count)
  );

  // The CPU sees reset on live clock edges as soon as reset is asserted.
  assign cpu_reset  = reset || (cur_state == ST_RESET_HOLD);
  assign cpu_clk_en = reset || clk_en;
  assign state      = cur_state;
  assign halt_cause = cause_q;

endmodule

// File: tb/tb_run_controller.sv
// Self-checking bench for run_controller: vector table through a scoreboard,
// plus timeout and saturation sequences on dedicated instances.
module tb_run_controller;
  import run_controller_pkg::*;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Main instance: RESET_CYCLES = 3, no timeout.
  logic        reset = 1'b1, run_mode = 1'b0, step_req = 1'b0, cpu_stop = 1'b0;
  logic [1:0]  cpu_error = 2'b00;
  logic        m_cpu_reset, m_clk_en, m_done;
  logic [2:0]  m_state;
  logic [1:0]  m_cause, m_errl;
  logic [31:0] m_count;

  run_controller #(.RESET_CYCLES(3), .ERROR_WIDTH(2), .COUNT_WIDTH(32), .MAX_CYCLES(0)) u_main (
    .clk(clk), .reset(reset), .run_mode(run_mode), .step_req(step_req),
    .cpu_stop(cpu_stop), .cpu_error(cpu_error), .cpu_reset(m_cpu_reset),
    .cpu_clk_en(m_clk_en), .state(m_state), .halt_cause(m_cause),
    .error_latched(m_errl), .cycle_count(m_count), .done(m_done)
  );

  // Timeout instance: MAX_CYCLES = 100, default reset hold.
  logic        t_rst = 1'b1;
  logic        zero1 = 1'b0;
  logic [1:0]  zero2 = 2'b00;
  logic        t_cpu_reset, t_clk_en, t_done;
  logic [2:0]  t_state;
  logic [1:0]  t_cause, t_errl;
  logic [31:0] t_count;

  run_controller #(.RESET_CYCLES(2), .ERROR_WIDTH(2), .COUNT_WIDTH(32), .MAX_CYCLES(100)) u_tmo (
    .clk(clk), .reset(t_rst), .run_mode(zero1), .step_req(zero1),
    .cpu_stop(zero1), .cpu_error(zero2), .cpu_reset(t_cpu_reset),
    .cpu_clk_en(t_clk_en), .state(t_state), .halt_cause(t_cause),
    .error_latched(t_errl), .cycle_count(t_count), .done(t_done)
  );

  // Saturation instance: 4-bit counter.
  logic        s_rst = 1'b1;
  logic        s_cpu_reset, s_clk_en, s_done;
  logic [2:0]  s_state;
  logic [1:0]  s_cause, s_errl;
  logic [3:0]  s_count;

  run_controller #(.RESET_CYCLES(2), .ERROR_WIDTH(2), .COUNT_WIDTH(4), .MAX_CYCLES(0)) u_sat (
    .clk(clk), .reset(s_rst), .run_mode(zero1), .step_req(zero1),
    .cpu_stop(zero1), .cpu_error(zero2), .cpu_reset(s_cpu_reset),
    .cpu_clk_en(s_clk_en), .state(s_state), .halt_cause(s_cause),
    .error_latched(s_errl), .cycle_count(s_count), .done(s_done)
  );

  typedef struct {
    string       name;
    logic        rst, mode, step, stop;
    logic [1:0]  err;
    int          n;
    logic        en;
    logic [2:0]  st;
    logic        crst;
    logic [1:0]  cause, errl;
    logic [31:0] cnt;
    logic        done;
  } vec_t;

  typedef struct {
    string       name;
    logic [2:0]  st;
    logic        crst;
    logic [1:0]  cause, errl;
    logic [31:0] cnt;
    logic        done;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void add(input string name, input logic rst, input logic mode,
                              input logic step, input logic stop, input logic [1:0] err,
                              input int n, input logic en, input logic [2:0] st,
                              input logic crst, input logic [1:0] cause,
                              input logic [1:0] errl, input logic [31:0] cnt,
                              input logic done);
    vec_t v;
    v.name = name; v.rst = rst; v.mode = mode; v.step = step; v.stop = stop; v.err = err;
    v.n = n; v.en = en; v.st = st; v.crst = crst; v.cause = cause; v.errl = errl;
    v.cnt = cnt; v.done = done;
    vecs.push_back(v);
  endfunction

  initial begin
    exp_t e;
    int   k;
    bit   seen;

    //   name            rst md st sp err   n  en state          crst cause       errl  cnt done
    add("rst_pulse",     1, 0, 0, 0, 2'b00, 1, 1, ST_RESET_HOLD, 1, HC_NONE,    2'b00, 0,  0);
    add("hold_err",      0, 0, 0, 0, 2'b11, 1, 1, ST_RESET_HOLD, 1, HC_NONE,    2'b00, 0,  0);
    add("hold_stop",     0, 0, 0, 1, 2'b01, 1, 1, ST_RESET_HOLD, 1, HC_NONE,    2'b00, 0,  0);
    add("hold_release",  0, 0, 0, 0, 2'b00, 1, 1, ST_RUN,        0, HC_NONE,    2'b00, 0,  0);
    add("free_run",      0, 0, 0, 0, 2'b00, 10, 1, ST_RUN,       0, HC_NONE,    2'b00, 10, 0);
    add("ebreak",        0, 0, 0, 1, 2'b00, 1, 1, ST_DRAIN,      0, HC_NONE,    2'b00, 11, 0);
    add("drain",         0, 0, 0, 0, 2'b00, 1, 0, ST_HALTED,     0, HC_EBREAK,  2'b00, 11, 1);
    add("halt_sticky",   0, 1, 1, 1, 2'b01, 3, 0, ST_HALTED,     0, HC_EBREAK,  2'b00, 11, 0);
    add("rst_halted",    1, 1, 0, 0, 2'b00, 1, 1, ST_RESET_HOLD, 1, HC_NONE,    2'b00, 0,  0);
    add("rel_step",      0, 1, 0, 0, 2'b00, 3, 1, ST_STEP_WAIT,  0, HC_NONE,    2'b00, 0,  0);
    add("step_idle_a",   0, 1, 0, 0, 2'b00, 4, 0, ST_STEP_WAIT,  0, HC_NONE,    2'b00, 0,  0);
    add("step_1",        0, 1, 1, 0, 2'b00, 1, 1, ST_STEP_WAIT,  0, HC_NONE,    2'b00, 1,  0);
    add("step_idle_b",   0, 1, 0, 0, 2'b00, 4, 0, ST_STEP_WAIT,  0, HC_NONE,    2'b00, 1,  0);
    add("step_2",        0, 1, 1, 0, 2'b00, 1, 1, ST_STEP_WAIT,  0, HC_NONE,    2'b00, 2,  0);
    add("step_idle_c",   0, 1, 0, 0, 2'b00, 4, 0, ST_STEP_WAIT,  0, HC_NONE,    2'b00, 2,  0);
    add("step_3",        0, 1, 1, 0, 2'b00, 1, 1, ST_STEP_WAIT,  0, HC_NONE,    2'b00, 3,  0);
    add("step_idle_d",   0, 1, 0, 0, 2'b00, 3, 0, ST_STEP_WAIT,  0, HC_NONE,    2'b00, 3,  0);
    add("step_4",        0, 1, 1, 0, 2'b00, 1, 1, ST_STEP_WAIT,  0, HC_NONE,    2'b00, 4,  0);
    add("step_idle_e",   0, 1, 0, 0, 2'b00, 1, 0, ST_STEP_WAIT,  0, HC_NONE,    2'b00, 4,  0);
    add("to_free",       0, 0, 0, 0, 2'b00, 1, 0, ST_RUN,        0, HC_NONE,    2'b00, 4,  0);
    add("free_resume",   0, 0, 0, 0, 2'b00, 3, 1, ST_RUN,        0, HC_NONE,    2'b00, 7,  0);
    add("step_held_a",   0, 1, 1, 0, 2'b00, 1, 1, ST_STEP_WAIT,  0, HC_NONE,    2'b00, 8,  0);
    add("step_held_b",   0, 1, 1, 0, 2'b00, 3, 1, ST_STEP_WAIT,  0, HC_NONE,    2'b00, 11, 0);
    add("step_idle_err", 0, 1, 0, 0, 2'b01, 1, 0, ST_ERROR,      0, HC_ERROR,   2'b01, 11, 1);
    add("err_sticky",    0, 0, 1, 0, 2'b10, 2, 0, ST_ERROR,      0, HC_ERROR,   2'b01, 11, 0);
    add("rst_error",     1, 0, 0, 0, 2'b00, 1, 1, ST_RESET_HOLD, 1, HC_NONE,    2'b00, 0,  0);
    add("rel_free",      0, 0, 0, 0, 2'b00, 3, 1, ST_RUN,        0, HC_NONE,    2'b00, 0,  0);
    add("run5",          0, 0, 0, 0, 2'b00, 5, 1, ST_RUN,        0, HC_NONE,    2'b00, 5,  0);
    add("err_and_stop",  0, 0, 0, 1, 2'b10, 1, 0, ST_ERROR,      0, HC_ERROR,   2'b10, 5,  1);
    add("err_hold",      0, 0, 0, 0, 2'b00, 1, 0, ST_ERROR,      0, HC_ERROR,   2'b10, 5,  0);
    add("rst_error2",    1, 0, 0, 0, 2'b00, 1, 1, ST_RESET_HOLD, 1, HC_NONE,    2'b00, 0,  0);
    add("rel_free2",     0, 0, 0, 0, 2'b00, 3, 1, ST_RUN,        0, HC_NONE,    2'b00, 0,  0);
    add("stop_b",        0, 0, 0, 1, 2'b00, 1, 1, ST_DRAIN,      0, HC_NONE,    2'b00, 1,  0);
    add("rst_in_drain",  1, 0, 0, 0, 2'b00, 1, 1, ST_RESET_HOLD, 1, HC_NONE,    2'b00, 0,  0);

    foreach (vecs[i]) begin
      for (int c = 0; c < vecs[i].n; c++) begin
        @(negedge clk);
        reset = vecs[i].rst; run_mode = vecs[i].mode; step_req = vecs[i].step;
        cpu_stop = vecs[i].stop; cpu_error = vecs[i].err;
        #1;
        chk({vecs[i].name, "/clk_en"}, 64'(m_clk_en), 64'(vecs[i].en));
        if (c == vecs[i].n - 1) begin
          e.name = vecs[i].name; e.st = vecs[i].st; e.crst = vecs[i].crst;
          e.cause = vecs[i].cause; e.errl = vecs[i].errl; e.cnt = vecs[i].cnt;
          e.done = vecs[i].done;
          sb.push_back(e);
        end
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk({e.name, "/state"},     64'(m_state),     64'(e.st));
          chk({e.name, "/cpu_reset"}, 64'(m_cpu_reset), 64'(e.crst));
          chk({e.name, "/cause"},     64'(m_cause),     64'(e.cause));
          chk({e.name, "/err_latch"}, 64'(m_errl),      64'(e.errl));
          chk({e.name, "/count"},     64'(m_count),     64'(e.cnt));
          chk({e.name, "/done"},      64'(m_done),      64'(e.done));
        end
      end
    end

    // Timeout: 2 hold edges then 100 enabled cycles, done after edge 102.
    @(negedge clk);
    t_rst = 1'b0;
    seen = 1'b0;
    k = 0;
    while (!seen && k < 300) begin
      @(posedge clk);
      #1;
      k++;
      if (k == 101) begin
        chk("tmo/last_en", 64'(t_clk_en), 64'd1);
        chk("tmo/count99", 64'(t_count), 64'd99);
      end
      if (t_done) seen = 1'b1;
    end
    chk("tmo/done_seen", 64'(seen), 64'd1);
    chk("tmo/edges",     64'(k), 64'd102);
    chk("tmo/state",     64'(t_state), 64'(ST_HALTED));
    chk("tmo/cause",     64'(t_cause), 64'(HC_TIMEOUT));
    chk("tmo/count",     64'(t_count), 64'd100);
    @(posedge clk);
    #1;
    chk("tmo/en_off",    64'(t_clk_en), 64'd0);
    chk("tmo/done_once", 64'(t_done), 64'd0);
    chk("tmo/count_hold", 64'(t_count), 64'd100);

    // Saturation: 2 hold edges then 20 free cycles on a 4-bit counter.
    @(negedge clk);
    s_rst = 1'b0;
    repeat (22) @(posedge clk);
    #1;
    chk("sat/count", 64'(s_count), 64'd15);
    chk("sat/state", 64'(s_state), 64'(ST_RUN));
    repeat (3) @(posedge clk);
    #1;
    chk("sat/no_wrap", 64'(s_count), 64'd15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
